// File: rtl/mips_pkg.sv
// Shared MIPS core types: ALU op encodings, register-zero index and default widths.
// No logic, no latency, no backpressure.
package mips_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;
  localparam int REG_ZERO               = 0;

  typedef enum logic [3:0] {
    OP_BUBBLE   = 4'd0,
    OP_SUB      = 4'd1,
    OP_OR       = 4'd2,
    OP_ADD      = 4'd3,
    OP_LUI      = 4'd4,
    OP_SLL      = 4'd5,
    OP_SRL      = 4'd6,
    OP_AND      = 4'd7,
    OP_NOR      = 4'd8,
    OP_NOTHING  = 4'd10,
    OP_NOTANDPC = 4'd11
  } alu_op_e;

endpackage

// File: rtl/forward_mux.sv
// Operand bypass select (EX/MEM over MEM/WB over register file, never for $0); combinational.
// No backpressure: pure function of its inputs.
module forward_mux
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic [DATA_WIDTH-1:0]     rf_data,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_data,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_data,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

  logic src_live;
  logic hit_exmem;
  logic hit_memwb;

  assign src_live  = (src_addr != ZERO_ADDR);
  assign hit_exmem = exmem_reg_write & (exmem_rd == src_addr) & src_live;
  assign hit_memwb = memwb_reg_write & (memwb_rd == src_addr) & src_live;

  always_comb begin
    fwd_data = rf_data;
    if (hit_exmem) begin
      fwd_data = exmem_data;
    end else if (hit_memwb) begin
      fwd_data = memwb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side bypass muxes and load-use detect; 1 cycle ID->EX.
// Backpressure: stall_i holds, stall_o stalls IF/ID and inserts a bubble; flush_i overrides both.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  input  logic [3:0]                alu_operation_i,
  input  logic [DATA_WIDTH-1:0]     rs_data_i,
  input  logic [DATA_WIDTH-1:0]     rt_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic                      alu_src_i,
  input  logic [4:0]                shamt_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rt_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic                      mem_to_reg_i,
  input  logic                      flush_i,
  input  logic                      stall_i,
  input  logic                      exmem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic [DATA_WIDTH-1:0]     exmem_data_i,
  input  logic                      memwb_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic [DATA_WIDTH-1:0]     memwb_data_i,
  output logic [3:0]                alu_operation_o,
  output logic [DATA_WIDTH-1:0]     a_o,
  output logic [DATA_WIDTH-1:0]     b_o,
  output logic [4:0]                shamt_o,
  output logic [DATA_WIDTH-1:0]     store_data_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      reg_write_o,
  output logic                      mem_read_o,
  output logic                      mem_write_o,
  output logic                      mem_to_reg_o,
  output logic                      valid_o,
  output logic                      stall_o
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

  typedef struct packed {
    logic                      valid;
    logic [3:0]                alu_op;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic                      alu_src;
    logic [4:0]                shamt;
    logic [REG_ADDR_WIDTH-1:0] rs_addr;
    logic [REG_ADDR_WIDTH-1:0] rt_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t id_in;
  id_ex_t bubble;
  logic [DATA_WIDTH-1:0] fwd_a;
  logic [DATA_WIDTH-1:0] fwd_b;

  always_comb begin
    id_in            = '0;
    id_in.valid      = valid_i;
    id_in.alu_op     = alu_operation_i;
    id_in.rs_data    = rs_data_i;
    id_in.rt_data    = rt_data_i;
    id_in.imm        = imm_i;
    id_in.alu_src    = alu_src_i;
    id_in.shamt      = shamt_i;
    id_in.rs_addr    = rs_addr_i;
    id_in.rt_addr    = rt_addr_i;
    id_in.rd_addr    = rd_addr_i;
    id_in.reg_write  = reg_write_i;
    id_in.mem_read   = mem_read_i;
    id_in.mem_write  = mem_write_i;
    id_in.mem_to_reg = mem_to_reg_i;
  end

  // Zeroed addresses keep a bubble from ever matching a bypass or hazard compare.
  always_comb begin
    bubble        = '0;
    bubble.alu_op = OP_BUBBLE;
  end

  // Load in EX whose destination is read by the instruction in ID; stores need rt even with an immediate.
  assign stall_o = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != ZERO_ADDR)
                 & ((ex_q.rd_addr == rs_addr_i)
                    | ((ex_q.rd_addr == rt_addr_i) & (!alu_src_i | mem_write_i)))
                 & valid_i & !flush_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else if (flush_i) begin
      ex_q <= bubble;
    end else if (!stall_i) begin
      ex_q <= stall_o ? bubble : id_in;
    end
  end

  forward_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_a (
    .src_addr        (ex_q.rs_addr),
    .rf_data         (ex_q.rs_data),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd        (exmem_rd_i),
    .exmem_data      (exmem_data_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_data      (memwb_data_i),
    .fwd_data        (fwd_a)
  );

  forward_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_b (
    .src_addr        (ex_q.rt_addr),
    .rf_data         (ex_q.rt_data),
    .exmem_reg_write (exmem_reg_write_i),
    .exmem_rd        (exmem_rd_i),
    .exmem_data      (exmem_data_i),
    .memwb_reg_write (memwb_reg_write_i),
    .memwb_rd        (memwb_rd_i),
    .memwb_data      (memwb_data_i),
    .fwd_data        (fwd_b)
  );

  assign alu_operation_o = ex_q.alu_op;
  assign a_o             = fwd_a;
  assign b_o             = ex_q.alu_src ? ex_q.imm : fwd_b;
  assign store_data_o    = fwd_b;
  assign shamt_o         = ex_q.shamt;
  assign rd_addr_o       = ex_q.rd_addr;
  assign reg_write_o     = ex_q.reg_write;
  assign mem_read_o      = ex_q.mem_read;
  assign mem_write_o     = ex_q.mem_write;
  assign mem_to_reg_o    = ex_q.mem_to_reg;
  assign valid_o         = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, bypass, $0 guard, load-use, flush, hold.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic        alu_src_i;
  logic [4:0]  shamt_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
  logic        flush_i, stall_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_data_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_data_i;
  logic [3:0]  alu_operation_o;
  logic [31:0] a_o, b_o, store_data_o;
  logic [4:0]  shamt_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .valid_i           (valid_i),
    .alu_operation_i   (alu_operation_i),
    .rs_data_i         (rs_data_i),
    .rt_data_i         (rt_data_i),
    .imm_i             (imm_i),
    .alu_src_i         (alu_src_i),
    .shamt_i           (shamt_i),
    .rs_addr_i         (rs_addr_i),
    .rt_addr_i         (rt_addr_i),
    .rd_addr_i         (rd_addr_i),
    .reg_write_i       (reg_write_i),
    .mem_read_i        (mem_read_i),
    .mem_write_i       (mem_write_i),
    .mem_to_reg_i      (mem_to_reg_i),
    .flush_i           (flush_i),
    .stall_i           (stall_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_data_i      (exmem_data_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_data_i      (memwb_data_i),
    .alu_operation_o   (alu_operation_o),
    .a_o               (a_o),
    .b_o               (b_o),
    .shamt_o           (shamt_o),
    .store_data_o      (store_data_o),
    .rd_addr_o         (rd_addr_o),
    .reg_write_o       (reg_write_o),
    .mem_read_o        (mem_read_o),
    .mem_write_o       (mem_write_o),
    .mem_to_reg_o      (mem_to_reg_o),
    .valid_o           (valid_o),
    .stall_o           (stall_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] op, input logic [4:0] rs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                        input logic asrc, input logic [31:0] imm, input logic rw, input logic mr,
                        input logic mw, input logic m2r);
    valid_i = v; alu_operation_i = op; rs_addr_i = rs; rs_data_i = rsd; rt_addr_i = rt;
    rt_data_i = rtd; rd_addr_i = rd; alu_src_i = asrc; imm_i = imm; shamt_i = 5'd0;
    reg_write_i = rw; mem_read_i = mr; mem_write_i = mw; mem_to_reg_i = m2r;
  endtask

  task automatic clear_fwd();
    exmem_reg_write_i = 1'b0; exmem_rd_i = 5'd0; exmem_data_i = 32'h0;
    memwb_reg_write_i = 1'b0; memwb_rd_i = 5'd0; memwb_data_i = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    clear_fwd();
    set_id(1, 4'd3, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 0, 32'h0, 1, 0, 0, 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (a_o !== 32'h0) begin n_fail++; $display("FAIL reset_a: got %h want 0", a_o); end
    n_checks++; if (b_o !== 32'h0) begin n_fail++; $display("FAIL reset_b: got %h want 0", b_o); end
    n_checks++; if (alu_operation_o !== 4'd0) begin n_fail++; $display("FAIL reset_op: got %h want 0", alu_operation_o); end
    n_checks++; if ({valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, stall_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                         {valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, stall_o});
    end
    #1 reset = 1'b0;
    tick();
    n_checks++; if (a_o !== 32'd5) begin n_fail++; $display("FAIL add_a: got %h want 5", a_o); end
    n_checks++; if (b_o !== 32'd7) begin n_fail++; $display("FAIL add_b: got %h want 7", b_o); end
    n_checks++; if (alu_operation_o !== 4'd3) begin n_fail++; $display("FAIL add_op: got %h want 3", alu_operation_o); end
    n_checks++; if (reg_write_o !== 1'b1 || valid_o !== 1'b1 || rd_addr_o !== 5'd3) begin
      n_fail++; $display("FAIL add_ctrl: got rw=%b v=%b rd=%0d want 1 1 3", reg_write_o, valid_o, rd_addr_o);
    end
  endtask

  task automatic test_exmem_bypass();
    clear_fwd();
    set_id(1, 4'd3, 5'd4, 32'h11, 5'd6, 32'h22, 5'd5, 0, 32'h0, 1, 0, 0, 0);
    tick();
    exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd4; exmem_data_i = 32'hAA;
    memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd4; memwb_data_i = 32'hBB;
    #1;
    n_checks++; if (a_o !== 32'hAA) begin n_fail++; $display("FAIL exmem_prio: got %h want aa", a_o); end
    exmem_reg_write_i = 1'b0;
    #1;
    n_checks++; if (a_o !== 32'hBB) begin n_fail++; $display("FAIL memwb_fwd: got %h want bb", a_o); end
    exmem_reg_write_i = 1'b1; memwb_rd_i = 5'd6; memwb_data_i = 32'hCC;
    #1;
    n_checks++; if (a_o !== 32'hAA || b_o !== 32'hCC || store_data_o !== 32'hCC) begin
      n_fail++; $display("FAIL split_fwd: got a=%h b=%h sd=%h want aa cc cc", a_o, b_o, store_data_o);
    end
    clear_fwd();
    #1;
    n_checks++; if (a_o !== 32'h11 || b_o !== 32'h22) begin
      n_fail++; $display("FAIL rf_path: got a=%h b=%h want 11 22", a_o, b_o);
    end
  endtask

  task automatic test_zero_guard();
    clear_fwd();
    set_id(1, 4'd3, 5'd0, 32'h0, 5'd2, 32'h44, 5'd7, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    tick();
    exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd0; exmem_data_i = 32'hFF;
    memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd2; memwb_data_i = 32'h55;
    #1;
    n_checks++; if (a_o !== 32'h0) begin n_fail++; $display("FAIL zero_guard: got %h want 0", a_o); end
    n_checks++; if (b_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL imm_b: got %h want fffffffc", b_o); end
    n_checks++; if (store_data_o !== 32'h55) begin n_fail++; $display("FAIL store_fwd: got %h want 55", store_data_o); end
  endtask

  task automatic test_load_use();
    clear_fwd();
    set_id(1, 4'd3, 5'd1, 32'h100, 5'd8, 32'h0, 5'd8, 1, 32'd4, 1, 1, 0, 1);
    tick();
    set_id(1, 4'd3, 5'd8, 32'h0, 5'd1, 32'h100, 5'd9, 0, 32'h0, 1, 0, 0, 0);
    #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall_o); end
    tick();
    n_checks++; if (valid_o !== 1'b0 || alu_operation_o !== 4'd0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL lu_bubble: got v=%b op=%h st=%b want 0 0 0", valid_o, alu_operation_o, stall_o);
    end
    memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd8; memwb_data_i = 32'hDEAD;
    tick();
    n_checks++; if (valid_o !== 1'b1 || a_o !== 32'hDEAD || b_o !== 32'h100 || rd_addr_o !== 5'd9) begin
      n_fail++; $display("FAIL lu_capture: got v=%b a=%h b=%h rd=%0d want 1 dead 100 9", valid_o, a_o, b_o, rd_addr_o);
    end
  endtask

  task automatic test_flush();
    clear_fwd();
    set_id(1, 4'd3, 5'd1, 32'h100, 5'd8, 32'h0, 5'd8, 1, 32'd4, 1, 1, 0, 1);
    tick();
    set_id(1, 4'd3, 5'd8, 32'h0, 5'd1, 32'h100, 5'd9, 0, 32'h0, 1, 0, 0, 0);
    flush_i = 1'b1; stall_i = 1'b1;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_mask: got %b want 0", stall_o); end
    tick();
    n_checks++; if (valid_o !== 1'b0 || mem_read_o !== 1'b0 || rd_addr_o !== 5'd0) begin
      n_fail++; $display("FAIL flush_bubble: got v=%b mr=%b rd=%0d want 0 0 0", valid_o, mem_read_o, rd_addr_o);
    end
    flush_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic test_hold();
    clear_fwd();
    set_id(1, 4'd2, 5'd3, 32'h70, 5'd4, 32'h80, 5'd10, 0, 32'h0, 1, 0, 0, 0);
    tick();
    stall_i = 1'b1;
    exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd3;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 4'(i + 5), 5'(i + 11), 32'(i), 5'(i + 12), 32'(i), 5'(i + 20), 0, 32'h0, 0, 0, 1, 0);
      exmem_data_i = 32'h1000 + 32'(i);
      tick();
      n_checks++;
      if (alu_operation_o !== 4'd2 || rd_addr_o !== 5'd10 || b_o !== 32'h80 || a_o !== 32'h1000 + 32'(i)) begin
        n_fail++; $display("FAIL hold_%0d: got op=%h rd=%0d a=%h b=%h want 2 10 %h 80",
                           i, alu_operation_o, rd_addr_o, a_o, b_o, 32'h1000 + 32'(i));
      end
    end
    stall_i = 1'b0;
    clear_fwd();
    tick();
    n_checks++; if (alu_operation_o !== 4'd7 || rd_addr_o !== 5'd22 || mem_write_o !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: got op=%h rd=%0d mw=%b want 7 22 1", alu_operation_o, rd_addr_o, mem_write_o);
    end
  endtask

  task automatic test_stall_hazard();
    clear_fwd();
    set_id(1, 4'd3, 5'd1, 32'h100, 5'd8, 32'h0, 5'd8, 1, 32'd4, 1, 1, 0, 1);
    tick();
    set_id(1, 4'd3, 5'd2, 32'h0, 5'd8, 32'h0, 5'd9, 0, 32'h0, 1, 0, 0, 0);
    stall_i = 1'b1;
    repeat (2) tick();
    n_checks++; if (stall_o !== 1'b1 || mem_read_o !== 1'b1 || rd_addr_o !== 5'd8) begin
      n_fail++; $display("FAIL stall_hold: got st=%b mr=%b rd=%0d want 1 1 8", stall_o, mem_read_o, rd_addr_o);
    end
    stall_i = 1'b0;
    tick();
    n_checks++; if (valid_o !== 1'b0 || stall_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_bubble: got v=%b st=%b want 0 0", valid_o, stall_o);
    end
    set_id(1, 4'd3, 5'd1, 32'h100, 5'd8, 32'h0, 5'd8, 1, 32'd4, 1, 1, 0, 1);
    tick();
    set_id(1, 4'd3, 5'd8, 32'h0, 5'd0, 32'h0, 5'd9, 1, 32'h0, 1, 0, 0, 0);
    #1;
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got %b want 1", stall_o); end
    reset = 1'b1;
    #1;
    n_checks++; if (stall_o !== 1'b0 || valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_midstall: got st=%b v=%b want 0 0", stall_o, valid_o);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_exmem_bypass();
    test_zero_guard();
    test_load_use();
    test_flush();
    test_hold();
    test_stall_hazard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the MIPS core. It captures decoded operands and control from ID and drives the ALU operation, A, B and shamt inputs in EX.
- Contains the EX-side forwarding muxes (EX/MEM and MEM/WB bypass) and load-use hazard detection.
- On a load-use hazard it inserts a bubble and stalls IF/ID.
- Applies a bubble on branch/jump flush, driven by the ALU's to-PC indication via the branch logic.

Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_WIDTH, 5, register-file address width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_i  in  1  ID holds a real instruction
- alu_operation_i  in  4  decoded ALU op
- rs_data_i, rt_data_i  in  DATA_WIDTH  register-file read data
- imm_i  in  DATA_WIDTH  sign/zero-extended immediate
- alu_src_i  in  1  1: B = immediate, 0: B = forwarded rt
- shamt_i  in  5  shift amount
- rs_addr_i, rt_addr_i, rd_addr_i  in  REG_ADDR_WIDTH  source/destination register numbers
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1  control for later stages
- flush_i  in  1  branch/jump taken; squash ID/EX contents
- stall_i  in  1  global hold from downstream (memory wait)
- exmem_reg_write_i  in  1; exmem_rd_i  in  REG_ADDR_WIDTH; exmem_data_i  in  DATA_WIDTH  EX/MEM bypass source
- memwb_reg_write_i  in  1; memwb_rd_i  in  REG_ADDR_WIDTH; memwb_data_i  in  DATA_WIDTH  MEM/WB bypass source
- alu_operation_o  out  4  to ALU
- a_o, b_o  out  DATA_WIDTH  to ALU operand inputs
- shamt_o  out  5  to ALU
- store_data_o  out  DATA_WIDTH  forwarded rt, for sw
- rd_addr_o  out  REG_ADDR_WIDTH; reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o  out  1  to EX/MEM
- stall_o  out  1  load-use stall to PC and IF/ID (hold)

Behaviour:
- Reset (async, immediate): all registered fields go to 0, so the stage holds a bubble.
  - Outputs at reset: alu_operation_o=4'b0000 (ALU default, result 0), a_o=b_o=store_data_o=0, all control outputs 0, stall_o=0.
- Register update priority per rising edge:
  - reset (async), then flush_i (load bubble, overrides stall_i), then stall_i (hold all fields), then stall_o (load bubble), then capture the ID inputs.
- Bubble definition:
  - valid, reg_write, mem_read, mem_write, mem_to_reg = 0; alu_operation = 0; rd_addr = 0.
  - Data and address fields = 0, so a bubble never forwards or hazards.
- Latency: ID inputs appear on the outputs one cycle after capture. Forwarding is combinational on the registered values.
- Forwarding per source (rs gives fwd_a, rt gives fwd_b):
  - If exmem_reg_write_i and exmem_rd_i == src and src != 0, select exmem_data_i.
  - Else if memwb_reg_write_i and memwb_rd_i == src and src != 0, select memwb_data_i.
  - Else select the registered register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - a_o = fwd_a
  - b_o = alu_src ? imm : fwd_b
  - store_data_o = fwd_b
  - shamt_o = registered shamt
- Load-use stall (combinational):
  - stall_o = valid_o & mem_read_o & (rd_addr_o != 0) & ((rd_addr_o == rs_addr_i) | (rd_addr_o == rt_addr_i & (!alu_src_i | mem_write_i))) & valid_i & !flush_i.
  - While stall_o=1, upstream holds the ID instruction; the next edge loads a bubble. The hazard clears because the bubble has mem_read=0.
- Stall interaction: stall_i=1 with stall_o=1 holds the register; stall_o stays asserted until stall_i drops, then the bubble is inserted.
- Flush:
  - flush_i=1 forces a bubble regardless of stall_i and stall_o.
  - stall_o is masked while flush_i=1, so the wrong-path instruction in ID does not stall.
- Reset mid-stall: all fields clear immediately; stall_o drops the same cycle because valid_o=0.

Decomposition:
- mips_pkg holds:
  - ALU op encodings SUB=1, OR=2, ADD=3, LUI=4, SLL=5, SRL=6, AND=7, NOR=8, NOTHING=10, NOTANDPC=11
  - OP_BUBBLE=0
  - REG_ZERO=0
  - DATA_WIDTH and REG_ADDR_WIDTH defaults
- Sub-module forward_mux: one combinational source-select. Instantiated twice (rs, rt).

Test Plan:
- Reset with inputs active: assert reset mid-cycle -> all outputs 0 immediately; after release, add $3,$1,$2 with rs=5, rt=7 -> next edge a_o=5, b_o=7, alu_operation_o=3, reg_write_o=1.
- EX/MEM bypass: registered rs=$4 (RF data 0x11); exmem_reg_write=1, exmem_rd=4, data 0xAA; memwb also rd=4, data 0xBB -> a_o=0xAA.
- $0 guard: rs=$0, exmem_rd=0, exmem_reg_write=1, data 0xFF -> a_o=0; addi with alu_src=1, imm=0xFFFF_FFFC -> b_o=0xFFFF_FFFC, store_data_o=forwarded rt.
- Load-use: lw $8 in EX, add $9,$8,$1 in ID -> stall_o=1 for exactly one cycle; next EX shows bubble (valid_o=0, alu_operation_o=0); the following cycle the add is captured, and with memwb_rd=8 forwarding the load data, a_o = load data.
- Flush priority: flush_i=1 with stall_i=1 and load-use pending -> next edge bubble, stall_o=0 during flush.
- Hold: stall_i=1 for 3 cycles with changing ID inputs -> outputs unchanged; forwarding still tracks changing exmem_data_i.
